// File: rtl/posit_defines.sv
// posit_defines: derived widths shared by the quire accumulator and its
// stage-1 shifter. Every helper takes the posit word width n and the
// exponent size es. The quire helper also takes the carry-guard bit count.
//   frac_w     : stored fraction bits (hidden bit excluded)
//   sf_w       : signed scale-factor width
//   nqmin      : minimum quire width that holds any exact posit product
//   quire_size : nqmin plus the carry-guard bits
//   bpp        : quire bit position of 2^0 (the binary point)
package posit_defines;

   function automatic int frac_w(input int n, input int es);
      return n - es - 32'sd3;
   endfunction

   function automatic int sf_w(input int n, input int es);
      return es + $clog2(n) + 32'sd2;
   endfunction

   function automatic int nqmin(input int n, input int es);
      return (32'sd1 << (es + 32'sd2)) * (n - 32'sd2) + 32'sd1;
   endfunction

   function automatic int quire_size(input int n, input int es, input int log_nb_accum);
      return nqmin(n, es) + log_nb_accum;
   endfunction

   function automatic int bpp(input int n, input int es);
      return (nqmin(n, es) - 32'sd1) / 32'sd2;
   endfunction

endpackage

// File: rtl/quire_shifter.sv
// quire_shifter: combinational alignment of one posit value onto the quire
// grid. The value (1.fraction)*2^scale is placed with its hidden bit at quire
// bit BPP+scale. Bits that fall below quire bit 0 are truncated.
// Ports:
//   fraction  in  FRAC_W         stored fraction bits
//   scale     in  SF_W (signed)  power-of-two scale
//   mag_o     out QUIRE_SIZE     aligned unsigned magnitude (0 when too big)
//   too_big_o out 1              scale exceeds BPP; the value does not fit
module quire_shifter
   import posit_defines::*;
#(
   parameter  int POSIT_WIDTH  = 8,
   parameter  int ES           = 0,
   parameter  int LOG_NB_ACCUM = 10,
   localparam int FRAC_W       = frac_w(POSIT_WIDTH, ES),
   localparam int SF_W         = sf_w(POSIT_WIDTH, ES),
   localparam int QUIRE_SIZE   = quire_size(POSIT_WIDTH, ES, LOG_NB_ACCUM),
   localparam int BPP          = bpp(POSIT_WIDTH, ES)
) (
   input  logic [FRAC_W-1:0]      fraction,
   input  logic signed [SF_W-1:0] scale,
   output logic [QUIRE_SIZE-1:0]  mag_o,
   output logic                   too_big_o
);

   logic [QUIRE_SIZE-1:0] mant_s;
   int                    shamt_s;

   assign mant_s = {{(QUIRE_SIZE-FRAC_W-1){1'b0}}, 1'b1, fraction};

   // The mantissa LSB sits FRAC_W bits below the hidden bit. A negative
   // amount therefore means a right shift that drops the low fraction bits.
   always_comb begin
      shamt_s   = BPP - FRAC_W + int'(scale);
      too_big_o = (int'(scale) > BPP);
      if (too_big_o) begin
         mag_o = {QUIRE_SIZE{1'b0}};
      end else if (shamt_s >= 32'sd0) begin
         mag_o = mant_s << shamt_s;
      end else begin
         mag_o = mant_s >> (-shamt_s);
      end
   end

endmodule

// File: rtl/quire_accum.sv
// quire_accum: two-stage posit quire accumulator with a ready/valid stream on
// both sides.
//   Stage 1 aligns the incoming value onto the quire grid.
//   Stage 2 adds or subtracts the aligned value in two's complement and keeps
//   the NaR and overflow sticky flags.
// A one-entry skid register absorbs the datum that can still arrive in the
// cycle after the output stalls, because rtr_o is registered.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rts_i / rtr_o              input valid / registered input ready
//   sow_i, eow_i               start / end of window markers
//   fraction, scale, sign_i    decoded posit value
//   zero_i, NaR_i              special-value flags
//   rtr_i / rts_o              output ready / output valid
//   sow_o, eow_o               window markers of the output beat
//   data_o                     quire contents (signed)
//   sign_o, zero_o             sign and zero test of data_o
//   NaR_o, ovf_o               sticky NaR and overflow flags of the window
module quire_accum
   import posit_defines::*;
#(
   parameter  int POSIT_WIDTH  = 8,
   parameter  int ES           = 0,
   parameter  int LOG_NB_ACCUM = 10,
   parameter  int OUT_MODE     = 0,
   localparam int FRAC_W       = frac_w(POSIT_WIDTH, ES),
   localparam int SF_W         = sf_w(POSIT_WIDTH, ES),
   localparam int QUIRE_SIZE   = quire_size(POSIT_WIDTH, ES, LOG_NB_ACCUM)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rts_i,
   output logic                         rtr_o,
   input  logic                         sow_i,
   input  logic                         eow_i,
   input  logic [FRAC_W-1:0]            fraction,
   input  logic signed [SF_W-1:0]       scale,
   input  logic                         sign_i,
   input  logic                         zero_i,
   input  logic                         NaR_i,
   input  logic                         rtr_i,
   output logic                         rts_o,
   output logic                         sow_o,
   output logic                         eow_o,
   output logic signed [QUIRE_SIZE-1:0] data_o,
   output logic                         sign_o,
   output logic                         zero_o,
   output logic                         NaR_o,
   output logic                         ovf_o
);

   localparam int IN_W        = FRAC_W + SF_W + 5;
   localparam bit WINDOW_ONLY = (OUT_MODE != 0);
   // Bit positions of the flags in the raw input bus.
   localparam int B_NAR  = FRAC_W + SF_W;
   localparam int B_ZERO = B_NAR + 1;
   localparam int B_SIGN = B_NAR + 2;
   localparam int B_EOW  = B_NAR + 3;
   localparam int B_SOW  = B_NAR + 4;
   // Bit positions of the flags carried by stage 1.
   localparam int F_BIG  = 0;
   localparam int F_NAR  = 1;
   localparam int F_ZERO = 2;
   localparam int F_SIGN = 3;
   localparam int F_EOW  = 4;
   localparam int F_SOW  = 5;

   logic                  process_en_s, accept_s, src_valid_s, too_big_s;
   logic [IN_W-1:0]       in_bus_s, src_bus_s;
   logic [QUIRE_SIZE-1:0] mag_s;

   logic                  rtr_q, rtr_d, skid_valid_q, skid_valid_d;
   logic [IN_W-1:0]       skid_q, skid_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [QUIRE_SIZE-1:0] s1_mag_q, s1_mag_d;
   logic [5:0]            s1_flags_q, s1_flags_d;
   logic [QUIRE_SIZE-1:0] quire_q, quire_d;
   logic                  nar_q, nar_d, ovf_q, ovf_d, open_q, open_d;
   logic                  rts_q, rts_d, sow_o_q, sow_o_d, eow_o_q, eow_o_d;

   logic                  eff_sow_s, skip_s, add_ovf_s;
   logic [QUIRE_SIZE-1:0] base_s, addend_s, sum_s;

   assign process_en_s = rtr_i | ~rts_q;
   assign accept_s     = rts_i & rtr_q;
   assign in_bus_s     = {sow_i, eow_i, sign_i, zero_i, NaR_i, scale, fraction};
   // A parked skid entry always goes ahead of the live input.
   assign src_valid_s  = skid_valid_q | accept_s;
   assign src_bus_s    = skid_valid_q ? skid_q : in_bus_s;

   quire_shifter #(
      .POSIT_WIDTH  (POSIT_WIDTH),
      .ES           (ES),
      .LOG_NB_ACCUM (LOG_NB_ACCUM)
   ) u_shifter (
      .fraction  (src_bus_s[FRAC_W-1:0]),
      .scale     (src_bus_s[FRAC_W+SF_W-1:FRAC_W]),
      .mag_o     (mag_s),
      .too_big_o (too_big_s)
   );

   // Input handshake, skid capture and stage-1 load.
   always_comb begin
      rtr_d        = process_en_s;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      s1_valid_d   = s1_valid_q;
      s1_mag_d     = s1_mag_q;
      s1_flags_d   = s1_flags_q;
      if (process_en_s) begin
         s1_valid_d = src_valid_s;
         s1_mag_d   = mag_s;
         // An out-of-range scale on a zero or NaR datum is not an overflow.
         s1_flags_d = {src_bus_s[B_SOW], src_bus_s[B_EOW], src_bus_s[B_SIGN],
                       src_bus_s[B_ZERO], src_bus_s[B_NAR],
                       too_big_s & ~src_bus_s[B_ZERO] & ~src_bus_s[B_NAR]};
         if (skid_valid_q) begin
            skid_valid_d = accept_s;
            skid_d       = in_bus_s;
         end else begin
            skid_valid_d = 1'b0;
         end
      end else begin
         // rtr_o lags process_en by one cycle, so one datum can still land here.
         if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_d       = in_bus_s;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // Stage 2: signed accumulate, sticky flags and the output beat.
   always_comb begin
      quire_d   = quire_q;
      nar_d     = nar_q;
      ovf_d     = ovf_q;
      open_d    = open_q;
      rts_d     = rts_q;
      sow_o_d   = sow_o_q;
      eow_o_d   = eow_o_q;
      // No window is open after reset or after an eow beat.
      eff_sow_s = s1_flags_q[F_SOW] | ~open_q;
      skip_s    = s1_flags_q[F_ZERO] | s1_flags_q[F_NAR] | s1_flags_q[F_BIG];
      base_s    = eff_sow_s ? {QUIRE_SIZE{1'b0}} : quire_q;
      if (skip_s) begin
         addend_s = {QUIRE_SIZE{1'b0}};
      end else if (s1_flags_q[F_SIGN]) begin
         addend_s = -s1_mag_q;
      end else begin
         addend_s = s1_mag_q;
      end
      sum_s     = base_s + addend_s;
      add_ovf_s = (base_s[QUIRE_SIZE-1] == addend_s[QUIRE_SIZE-1]) &
                  (sum_s[QUIRE_SIZE-1] != base_s[QUIRE_SIZE-1]);
      if (process_en_s) begin
         if (s1_valid_q) begin
            quire_d = sum_s;
            nar_d   = (~eff_sow_s & nar_q) | s1_flags_q[F_NAR];
            ovf_d   = (~eff_sow_s & ovf_q) | s1_flags_q[F_BIG] | add_ovf_s;
            open_d  = ~s1_flags_q[F_EOW];
            rts_d   = WINDOW_ONLY ? s1_flags_q[F_EOW] : 1'b1;
            sow_o_d = eff_sow_s & (~WINDOW_ONLY | s1_flags_q[F_EOW]);
            eow_o_d = s1_flags_q[F_EOW];
         end else begin
            rts_d   = 1'b0;
            sow_o_d = 1'b0;
            eow_o_d = 1'b0;
         end
      end else begin
         rts_d = rts_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rtr_q        <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_q       <= {IN_W{1'b0}};
         s1_valid_q   <= 1'b0;
         s1_mag_q     <= {QUIRE_SIZE{1'b0}};
         s1_flags_q   <= 6'b000000;
         quire_q      <= {QUIRE_SIZE{1'b0}};
         nar_q        <= 1'b0;
         ovf_q        <= 1'b0;
         open_q       <= 1'b0;
         rts_q        <= 1'b0;
         sow_o_q      <= 1'b0;
         eow_o_q      <= 1'b0;
      end else begin
         rtr_q        <= rtr_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         s1_valid_q   <= s1_valid_d;
         s1_mag_q     <= s1_mag_d;
         s1_flags_q   <= s1_flags_d;
         quire_q      <= quire_d;
         nar_q        <= nar_d;
         ovf_q        <= ovf_d;
         open_q       <= open_d;
         rts_q        <= rts_d;
         sow_o_q      <= sow_o_d;
         eow_o_q      <= eow_o_d;
      end
   end

   assign rtr_o  = rtr_q;
   assign rts_o  = rts_q;
   assign sow_o  = sow_o_q;
   assign eow_o  = eow_o_q;
   assign data_o = quire_q;
   assign sign_o = quire_q[QUIRE_SIZE-1];
   assign zero_o = (quire_q == {QUIRE_SIZE{1'b0}});
   assign NaR_o  = nar_q;
   assign ovf_o  = ovf_q;

endmodule

// File: doc/quire_accum.md
QUIRE_ACCUM -- requirements
Module: quire_accum

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 8: posit word width N.
REQ-002 SHALL have parameter ES, default 0: posit exponent size.
REQ-003 SHALL have parameter LOG_NB_ACCUM, default 10: quire carry-guard bits.
REQ-004 SHALL have parameter OUT_MODE, default 0: 0 = emit running sum per datum; 1 = emit only the window result on the eow beat.
REQ-005 SHALL derive FRAC_W = N-ES-3, SF_W = ES+clog2(N)+2, NQMIN = 2^(ES+2)*(N-2)+1, QUIRE_SIZE = NQMIN+LOG_NB_ACCUM, BPP = (NQMIN-1)/2.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset; rts_i in 1; rtr_o out 1; sow_i in 1; eow_i in 1; fraction in FRAC_W; scale in SF_W signed; sign_i in 1; zero_i in 1; NaR_i in 1; rtr_i in 1; rts_o out 1; sow_o out 1; eow_o out 1; data_o out QUIRE_SIZE signed; sign_o out 1; zero_o out 1; NaR_o out 1; ovf_o out 1.
REQ-007 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-008 SHALL transfer an input datum on a rising clk edge when rts_i and rtr_o are both 1.
REQ-009 SHALL drive rtr_o as a registered copy of process_en = rtr_i | ~rts_o.
REQ-010 SHALL capture a datum arriving while process_en is 0 in a one-entry skid register and process it before any new input.
REQ-011 SHALL form a value of (1.fraction)*2^scale, with the hidden bit at quire bit BPP+scale.
REQ-012 SHALL align the value by a left shift of BPP+scale-FRAC_W when this amount is non-negative, else by a right shift with the dropped bits truncated.
REQ-013 SHALL on scale > BPP set the ovf sticky flag and contribute 0 to the sum.
REQ-014 SHALL add the aligned value to the quire when sign is 0 and subtract it when sign is 1, in two's complement modulo 2^QUIRE_SIZE.
REQ-015 SHALL on a sow datum load the quire with +/- the aligned value, or with 0 if zero_i is 1, and clear the NaR and ovf sticky flags.
REQ-016 SHALL treat the first datum after an eow beat as an implicit sow.
REQ-017 SHALL handle sow and eow on the same datum as a single-element window.
REQ-018 SHALL leave the quire unchanged on a zero datum that is not sow.
REQ-019 SHALL on a NaR datum set the NaR sticky flag without changing the quire; NaR_o reports the sticky flag.
REQ-020 SHALL set the ovf sticky flag on signed add/sub overflow; ovf_o reports the flag.
REQ-021 SHALL have latency 2 cycles from acceptance to rts_o (stage 1: align; stage 2: accumulate).
REQ-022 SHALL in OUT_MODE 0 assert rts_o once per accepted datum, with data_o = running sum.
REQ-023 SHALL in OUT_MODE 1 assert rts_o only for eow data, with eow_o = 1 and sow_o = 1 only for a single-element window.
REQ-024 SHALL drive sign_o = data_o[MSB] and zero_o = (data_o == 0).
REQ-025 SHALL hold all outputs stable while rts_o is 1 and rtr_i is 0.
REQ-026 SHALL stall both pipeline stages while process_en is 0, and SHALL NOT drop or duplicate data.

Reset
REQ-027 SHALL on rst clear the stage valid bits, skid register, quire, NaR/ovf sticky flags, sow_o, eow_o, rts_o and rtr_o, so that data_o is 0 and zero_o is 1.
REQ-028 SHALL abandon a window that is partially accumulated when rst is asserted; the first datum after reset starts a new window.

Structure
REQ-029 SHALL place the FRAC_W, SF_W, NQMIN, QUIRE_SIZE and BPP derivation functions in package posit_defines.
REQ-030 SHALL implement stage-1 alignment in sub-module quire_shifter.

Verification (N=8, ES=0, LOG_NB_ACCUM=4: QUIRE_SIZE=29, BPP=12, FRAC_W=5, SF_W=5)
REQ-031 Single window, sow=eow=1, fraction=0, scale=0, sign=0 -> rts_o 2 cycles later, data_o=0x1000, sow_o=eow_o=1.
REQ-032 OUT_MODE=1, window +1.0 / +1.5 (fraction=5'b10000, scale=0) / -0.5 (scale=-1, sign=1) -> exactly one rts_o beat, data_o=0x2000, eow_o=1.
REQ-033 NaR on datum 2 of a 4-datum window, then a clean window -> NaR_o=1 on the first result and 0 on the second.
REQ-034 fraction=5'b11111, scale=12, nine data in one window -> after 8 data data_o=0xFC00000 and ovf_o=0; after the 9th, ovf_o=1.
REQ-035 rts_i held high for 8 data while rtr_i is low for cycles 3-5 -> rtr_o falls one cycle late, the skid register is used, the sum is exact and no beat is lost or duplicated.
REQ-036 rst pulsed in the middle of a window -> rts_o=0 and data_o=0 the next cycle; the following window's result contains none of the pre-reset data.
